// File: rtl/block_deinterleaver.sv
// block_deinterleaver: column-major bit stream in, row-major block out, ROWS x COLS flop matrix.
// Define DEINTLV_PINGPONG_EN for two banks so one block fills while the other drains.
module block_deinterleaver #(
    parameter int ROWS = 4,
    parameter int COLS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_ready,
    output logic out_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_last
);
`ifdef DEINTLV_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] CMAX = CW'(COLS - 1);

    typedef enum logic {FILL, DRAIN} state_t;
    state_t state, state_nx;

    logic          mat [2][ROWS][COLS];
    logic [RW-1:0] wr_row, rd_row, nx_row;
    logic [CW-1:0] wr_col, rd_col, nx_col;
    logic          wbank, rbank, fill_done;
    logic          in_xfer, out_xfer, fill_cpl, drain_cpl, swap;

    // With a single bank PP=0 pins both bank selects to bank 0.
    assign rbank     = wbank ^ PP;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign fill_cpl  = in_xfer && wr_row == RMAX && wr_col == CMAX;
    assign drain_cpl = out_xfer && out_last;
    assign swap      = (fill_cpl || fill_done) && (state == FILL || drain_cpl);
    assign nx_col    = rd_col == CMAX ? '0 : rd_col + 1'b1;
    assign nx_row    = rd_col != CMAX ? rd_row : rd_row == RMAX ? '0 : rd_row + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = swap ? DRAIN : drain_cpl ? FILL : state;
    end

    always_comb begin
        out_valid = state == DRAIN;
        in_ready  = !reset && (PP ? !fill_done : state == FILL);
    end

    // Matrix is deliberately not reset; a partial block is simply overwritten.
    always_ff @(posedge clk) begin
        if (in_xfer) mat[wbank][wr_row][wr_col] <= in_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_row    <= '0;
            wr_col    <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            wbank     <= 1'b0;
            fill_done <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (in_xfer) begin
                wr_row <= wr_row == RMAX ? '0 : wr_row + 1'b1;
                if (wr_row == RMAX) wr_col <= wr_col == CMAX ? '0 : wr_col + 1'b1;
            end
            fill_done <= (fill_cpl || fill_done) && !swap;
            if (swap) begin
                wbank    <= wbank ^ PP;
                rd_row   <= '0;
                rd_col   <= '0;
                out_bit  <= mat[wbank][0][0];
                out_last <= 1'b0;
            end else if (out_xfer) begin
                rd_row   <= nx_row;
                rd_col   <= nx_col;
                out_bit  <= mat[rbank][nx_row][nx_col];
                out_last <= nx_row == RMAX && nx_col == CMAX;
            end
        end
    end
endmodule

// File: tb/tb_block_deinterleaver.sv
// tb_block_deinterleaver: directed tests on a 2x3 instance and a 4x8 instance for back-to-back blocks.
module tb_block_deinterleaver;
    logic clk = 1'b0, reset = 1'b1;
    logic in_bit_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic in_ready_a, out_bit_a, out_valid_a, out_last_a;
    logic in_bit_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic in_ready_b, out_bit_b, out_valid_b, out_last_b;
    int checks = 0, errors = 0;
    logic [31:0] data [3] = '{32'hA5C3_1E79, 32'h0F0F_3366, 32'hDEAD_BEEF};

    always #5 clk = ~clk;

    block_deinterleaver #(.ROWS(2), .COLS(3)) dut_a (
        .clk(clk), .reset(reset), .in_bit(in_bit_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_bit(out_bit_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_last(out_last_a)
    );

    block_deinterleaver #(.ROWS(4), .COLS(8)) dut_b (
        .clk(clk), .reset(reset), .in_bit(in_bit_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_bit(out_bit_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_last(out_last_b)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // bits[k] is input index k; early reports out_valid seen before the last input
    task automatic fill_a(input logic [5:0] bits, input bit gaps, output bit early);
        early = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid_a) early = 1'b1;
            in_bit_a   = bits[k];
            in_valid_a = 1'b1;
            step();
            in_valid_a = 1'b0;
            in_bit_a   = 1'b0;
            if (gaps && k < 5) step();
        end
    endtask

    // got[n]/lasts[n] are output index n; pat[cyc%3] drives out_ready
    task automatic drain_a(input logic [2:0] pat, output logic [5:0] got, output logic [5:0] lasts,
                           output int stall_err, output int rdy_err, output bit timeout);
        int n = 0;
        bit held = 1'b0;
        logic hb = 1'b0, hl = 1'b0;
        got = '0;
        lasts = '0;
        stall_err = 0;
        rdy_err = 0;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            out_ready_a = pat[cyc % 3];
            if (held && (out_bit_a !== hb || out_last_a !== hl)) stall_err++;
            if (out_valid_a && in_ready_a) rdy_err++;
            if (out_valid_a && out_ready_a) begin
                got[n]   = out_bit_a;
                lasts[n] = out_last_a;
                n++;
                held = 1'b0;
            end else if (out_valid_a) begin
                held = 1'b1;
                hb = out_bit_a;
                hl = out_last_a;
            end
            step();
        end
        out_ready_a = 1'b0;
        timeout = n < 6;
    endtask

    task automatic test_reset;
        #3;
        checks += 4;
        if (in_ready_a !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_a); end
        if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a); end
        if (out_bit_a !== 1'b0) begin errors++; $display("FAIL reset_out_bit: got %b expected 0", out_bit_a); end
        if (out_last_a !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last_a); end
        step();
        reset = 1'b0;
        #1;
        checks += 2;
        if (in_ready_a !== 1'b1) begin errors++; $display("FAIL release_in_ready_a: got %b expected 1", in_ready_a); end
        if (in_ready_b !== 1'b1) begin errors++; $display("FAIL release_in_ready_b: got %b expected 1", in_ready_b); end
        step();
    endtask

    task automatic test_basic_order;
        bit early, to;
        logic [5:0] got, lasts;
        int se, re;
        fill_a(6'b011001, 1'b0, early);
        checks += 2;
        if (early !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", early); end
        if (out_valid_a !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", out_valid_a); end
        drain_a(3'b111, got, lasts, se, re, to);
        checks += 3;
        if (to) begin errors++; $display("FAIL basic_timeout: got %b expected 0", to); end
        if (got !== 6'b010101) begin errors++; $display("FAIL basic_bits: got %b expected 010101", got); end
        if (lasts !== 6'b100000) begin errors++; $display("FAIL basic_last: got %b expected 100000", lasts); end
    endtask

    task automatic test_index;
        bit early, to;
        logic [5:0] got, lasts;
        int se, re;
        fill_a(6'b001000, 1'b0, early);
        drain_a(3'b111, got, lasts, se, re, to);
        checks += 2;
        if (to) begin errors++; $display("FAIL index_timeout: got %b expected 0", to); end
        if (got !== 6'b010000) begin errors++; $display("FAIL index_bits: got %b expected 010000", got); end
    endtask

    task automatic test_backpressure;
        bit early, to;
        logic [5:0] got, lasts;
        int se, re;
        fill_a(6'b011001, 1'b0, early);
        drain_a(3'b001, got, lasts, se, re, to);
        checks += 4;
        if (to) begin errors++; $display("FAIL bp_timeout: got %b expected 0", to); end
        if (se != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", se); end
        if (got !== 6'b010101) begin errors++; $display("FAIL bp_bits: got %b expected 010101", got); end
        if (lasts !== 6'b100000) begin errors++; $display("FAIL bp_last: got %b expected 100000", lasts); end
    endtask

    task automatic test_input_gaps;
        bit early, to;
        logic [5:0] got, lasts;
        int se, re;
        fill_a(6'b011001, 1'b1, early);
        checks += 2;
        if (early !== 1'b0) begin errors++; $display("FAIL gaps_early_valid: got %b expected 0", early); end
        if (out_valid_a !== 1'b1) begin errors++; $display("FAIL gaps_latency: got %b expected 1", out_valid_a); end
        drain_a(3'b111, got, lasts, se, re, to);
        checks += 2;
        if (to) begin errors++; $display("FAIL gaps_timeout: got %b expected 0", to); end
        if (got !== 6'b010101) begin errors++; $display("FAIL gaps_bits: got %b expected 010101", got); end
`ifndef DEINTLV_PINGPONG_EN
        checks++;
        if (re != 0) begin errors++; $display("FAIL gaps_in_ready_drain: got %0d high cycles expected 0", re); end
`endif
    endtask

    task automatic test_reset_mid_drain;
        bit early, to;
        logic [5:0] got, lasts;
        int se, re;
        fill_a(6'b011001, 1'b0, early);
        out_ready_a = 1'b1;
        step();
        step();
        out_ready_a = 1'b0;
        reset = 1'b1;
        #1;
        checks += 3;
        if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid_a); end
        if (in_ready_a !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready_a); end
        if (out_bit_a !== 1'b0) begin errors++; $display("FAIL rst_mid_out_bit: got %b expected 0", out_bit_a); end
        #1;
        reset = 1'b0;
        step();
        checks++;
        if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_after_out_valid: got %b expected 0", out_valid_a); end
        fill_a(6'b110100, 1'b0, early);
        drain_a(3'b111, got, lasts, se, re, to);
        checks += 3;
        if (to) begin errors++; $display("FAIL rst_fresh_timeout: got %b expected 0", to); end
        if (got !== 6'b100110) begin errors++; $display("FAIL rst_fresh_bits: got %b expected 100110", got); end
        if (lasts !== 6'b100000) begin errors++; $display("FAIL rst_fresh_last: got %b expected 100000", lasts); end
    endtask

    // Block b input k is data[b][k]; output n of a block is row n/8, col n%8 -> input k = col*4 + row.
    task automatic test_back_to_back;
        int drops, lasts, nout, k, cyc_i, cyc_o, m;
        bit acc;
        logic ex, exl;
        drops = 0;
        lasts = 0;
        nout = 0;
        k = 0;
        out_ready_b = 1'b1;
        fork
            begin
                for (cyc_i = 0; cyc_i < 2000 && k < 96; cyc_i++) begin
                    in_valid_b = 1'b1;
                    in_bit_b = data[k / 32][k % 32];
                    acc = in_ready_b;
                    if (!acc) drops++;
                    step();
                    if (acc) k++;
                end
                in_valid_b = 1'b0;
            end
            begin
                for (cyc_o = 0; cyc_o < 3000 && nout < 96; cyc_o++) begin
                    if (out_valid_b) begin
                        m = nout % 32;
                        ex = data[nout / 32][(m % 8) * 4 + m / 8];
                        exl = m == 31;
                        checks += 2;
                        if (out_bit_b !== ex) begin errors++; $display("FAIL b2b_bit[%0d]: got %b expected %b", nout, out_bit_b, ex); end
                        if (out_last_b !== exl) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", nout, out_last_b, exl); end
                        if (out_last_b) lasts++;
                        nout++;
                    end
                    step();
                end
            end
        join
        out_ready_b = 1'b0;
        checks += 3;
        if (k != 96) begin errors++; $display("FAIL b2b_inputs: got %0d expected 96", k); end
        if (nout != 96) begin errors++; $display("FAIL b2b_outputs: got %0d expected 96", nout); end
        if (lasts != 3) begin errors++; $display("FAIL b2b_last_count: got %0d expected 3", lasts); end
`ifdef DEINTLV_PINGPONG_EN
        checks++;
        if (drops != 0) begin errors++; $display("FAIL b2b_in_ready_drops: got %0d expected 0", drops); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_index();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
